// File: rtl/axi4_lite_system_top.sv
// axi4_lite_system_top
// Self-contained AXI4-Lite loopback: a request/done front-end drives an
// internal AXI4-Lite master wired to an internal AXI4-Lite slave backed by a
// MEM_DEPTH x 32-bit register memory. Write and read channels are independent.
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous, active-high
//   write_req            start a write (ignored while a write is in flight)
//   write_addr/data/strb captured with write_req
//   write_done           one-cycle pulse when the B response arrives
//   write_resp           BRESP of the last completed write (held)
//   read_req             start a read (ignored while a read is in flight)
//   read_addr            captured with read_req
//   read_data/read_resp  RDATA/RRESP of the last completed read (held)
//   read_done            one-cycle pulse when the R beat arrives
module axi4_lite_system_top #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [STRB_WIDTH-1:0] write_strb,
  output logic                  write_done,
  output logic [1:0]            write_resp,
  input  logic                  read_req,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_done,
  output logic [1:0]            read_resp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t r_wstate;
  rstate_t r_rstate;

  // Master-side AXI signals
  logic                  r_awvalid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_wvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_bready;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_rready;

  // Slave-side AXI signals
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Front-end result registers
  logic                  r_write_done;
  logic [1:0]            r_write_resp;
  logic                  r_read_done;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic [1:0]            r_read_resp;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [ADDR_WIDTH-1:0] w_aw_word, w_ar_word;
  logic                  w_aw_ok, w_ar_ok;
  logic [IDX_W-1:0]      w_aw_idx, w_ar_idx;

  assign w_aw_hs = r_awvalid & r_awready;
  assign w_w_hs  = r_wvalid  & r_wready;
  assign w_b_hs  = r_bvalid  & r_bready;
  assign w_ar_hs = r_arvalid & r_arready;
  assign w_r_hs  = r_rvalid  & r_rready;

  // Word addresses: the byte offset is dropped, anything above the memory
  // index range makes the access invalid.
  assign w_aw_word = r_awaddr >> 2;
  assign w_ar_word = r_araddr >> 2;
  assign w_aw_ok   = ((w_aw_word >> IDX_W) == '0);
  assign w_ar_ok   = ((w_ar_word >> IDX_W) == '0);
  assign w_aw_idx  = w_aw_word[IDX_W-1:0];
  assign w_ar_idx  = w_ar_word[IDX_W-1:0];

  assign write_done = r_write_done;
  assign write_resp = r_write_resp;
  assign read_done  = r_read_done;
  assign read_data  = r_read_data;
  assign read_resp  = r_read_resp;

  // Master write FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate     <= W_IDLE;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_write_done <= 1'b0;
      r_write_resp <= '0;
    end else begin
      r_write_done <= 1'b0;
      case (r_wstate)
        W_IDLE: begin
          if (write_req) begin
            r_awaddr  <= write_addr;
            r_wdata   <= write_data;
            r_wstrb   <= write_strb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wstate  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          // Move on once both channels have completed, in any order.
          if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
            r_bready <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bready     <= 1'b0;
            r_write_resp <= r_bresp;
            r_write_done <= 1'b1;
            r_wstate     <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Master read FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate    <= R_IDLE;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_araddr    <= '0;
      r_read_done <= 1'b0;
      r_read_data <= '0;
      r_read_resp <= '0;
    end else begin
      r_read_done <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          if (read_req) begin
            r_araddr  <= read_addr;
            r_arvalid <= 1'b1;
            r_rstate  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_read_data <= r_rdata;
            r_read_resp <= r_rresp;
            r_read_done <= 1'b1;
            r_rstate    <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Slave write path and memory
  always_ff @(posedge clk) begin
    if (reset) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      // The !r_awready term keeps the ready pulse to a single cycle.
      if (r_awvalid && r_wvalid && !r_bvalid && !r_awready) begin
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
      if (w_aw_hs && w_w_hs) begin
        r_bvalid <= 1'b1;
        if (w_aw_ok) begin
          r_bresp <= RESP_OKAY;
          for (int unsigned i = 0; i < STRB_WIDTH; i++)
            if (r_wstrb[i]) r_mem[w_aw_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end else begin
          r_bresp <= RESP_SLVERR;
        end
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Slave read path; a same-cycle write is not visible (pre-write value).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
    end else begin
      r_arready <= 1'b0;
      if (r_arvalid && !r_arready && !r_rvalid) r_arready <= 1'b1;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        if (w_ar_ok) begin
          r_rdata <= r_mem[w_ar_idx];
          r_rresp <= RESP_OKAY;
        end else begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_system_top.sv
// Testbench for axi4_lite_system_top: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-level model (fixed 3-edge latency, word array, busy tracking).
module tb_axi4_lite_system_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_req = 1'b0;
  logic [31:0] write_addr = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strb = '0;
  logic        read_req = 1'b0;
  logic [31:0] read_addr = '0;
  logic        write_done, read_done;
  logic [1:0]  write_resp, read_resp;
  logic [31:0] read_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi4_lite_system_top #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH (256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .write_req (write_req),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_strb(write_strb),
    .write_done(write_done),
    .write_resp(write_resp),
    .read_req  (read_req),
    .read_addr (read_addr),
    .read_data (read_data),
    .read_done (read_done),
    .read_resp (read_resp)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [0:255];
  bit          m_w_act = 0, m_r_act = 0;
  int          m_w_cnt = 0, m_r_cnt = 0;
  logic [1:0]  m_w_pend = '0, m_r_pend_resp = '0;
  logic [31:0] m_r_pend_data = '0;
  logic        exp_wdone = 1'b0, exp_rdone = 1'b0;
  logic [1:0]  exp_wresp = '0, exp_rresp = '0;
  logic [31:0] exp_rdata = '0;

  always @(posedge clk) begin : model
    bit acc_w, acc_r;
    logic [31:0] word, mask;
    if (reset) begin
      for (int i = 0; i < 256; i++) m_mem[i] = '0;
      m_w_act = 0; m_r_act = 0;
      exp_wdone = 0; exp_rdone = 0;
      exp_wresp = 0; exp_rresp = 0; exp_rdata = 0;
    end else begin
      acc_w = write_req && !m_w_act;
      acc_r = read_req && !m_r_act;
      exp_wdone = 0;
      exp_rdone = 0;
      if (m_w_act) begin
        m_w_cnt--;
        if (m_w_cnt == 0) begin
          exp_wdone = 1; exp_wresp = m_w_pend; m_w_act = 0;
        end
      end
      if (m_r_act) begin
        m_r_cnt--;
        if (m_r_cnt == 0) begin
          exp_rdone = 1; exp_rresp = m_r_pend_resp; exp_rdata = m_r_pend_data;
          m_r_act = 0;
        end
      end
      // Read before write: a same-edge read sees the old word.
      if (acc_r) begin
        m_r_act = 1; m_r_cnt = 3;
        if (read_addr < 32'h400) begin
          m_r_pend_data = m_mem[read_addr / 4]; m_r_pend_resp = 2'd0;
        end else begin
          m_r_pend_data = 0; m_r_pend_resp = 2'd2;
        end
      end
      if (acc_w) begin
        m_w_act = 1; m_w_cnt = 3;
        if (write_addr < 32'h400) begin
          word = m_mem[write_addr / 4];
          for (int b = 0; b < 4; b++) begin
            mask = 32'hFF << (8 * b);
            if (write_strb[b]) word = (word & ~mask) | (write_data & mask);
          end
          m_mem[write_addr / 4] = word;
          m_w_pend = 2'd0;
        end else begin
          m_w_pend = 2'd2;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("write_done", 32'(write_done), 32'(exp_wdone));
    chk("write_resp", 32'(write_resp), 32'(exp_wresp));
    chk("read_done",  32'(read_done),  32'(exp_rdone));
    chk("read_data",  read_data,       exp_rdata);
    chk("read_resp",  32'(read_resp),  32'(exp_rresp));
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] er);
    bit seen;
    int lat;
    seen = 0; lat = 0;
    write_req = 1; write_addr = a; write_data = d; write_strb = s;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) write_req = 0;
      if (write_done) begin
        seen = 1; lat = k - 1; break;
      end
    end
    if (!seen) chk("write_done_timeout", 32'd0, 32'd1);
    else begin
      chk("write_latency", 32'(lat), 32'd3);
      chk("write_resp_lit", 32'(write_resp), 32'(er));
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit seen;
    int lat;
    seen = 0; lat = 0;
    read_req = 1; read_addr = a;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) read_req = 0;
      if (read_done) begin
        seen = 1; lat = k - 1; break;
      end
    end
    if (!seen) chk("read_done_timeout", 32'd0, 32'd1);
    else begin
      chk("read_latency", 32'(lat), 32'd3);
      chk("read_data_lit", read_data, ed);
      chk("read_resp_lit", 32'(read_resp), 32'(er));
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int dones;

    // Reset
    reset = 1;
    repeat (5) tick();
    chk("rst_write_done", 32'(write_done), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_read_resp", 32'(read_resp), 32'd0);
    reset = 0;
    tick();

    // Basic write/read
    wr(32'h000, 32'hDEADBEEF, 4'hF, 2'd0);
    rd(32'h000, 32'hDEADBEEF, 2'd0);

    // Byte strobes
    wr(32'h004, 32'h12345678, 4'h3, 2'd0);
    rd(32'h004, 32'h00005678, 2'd0);
    wr(32'h004, 32'hAABBCCDD, 4'h8, 2'd0);
    rd(32'h004, 32'hAA005678, 2'd0);

    // Sequential words and overwrite
    for (int i = 0; i < 4; i++) wr(32'h010 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF, 2'd0);
    for (int i = 0; i < 4; i++) rd(32'h010 + 32'(4 * i), 32'hA0000000 + 32'(i), 2'd0);
    wr(32'h020, 32'hCAFEBABE, 4'hF, 2'd0);
    rd(32'h020, 32'hCAFEBABE, 2'd0);
    wr(32'h020, 32'hFEEDFACE, 4'hF, 2'd0);
    rd(32'h020, 32'hFEEDFACE, 2'd0);

    // Invalid address
    wr(32'hFFFFFFFF, 32'h11111111, 4'hF, 2'd2);
    rd(32'hFFFFFFFF, 32'h00000000, 2'd2);
    rd(32'h3FC, 32'h00000000, 2'd0);

    // Top word, boundary, unaligned, zero strobe
    wr(32'h3FC, 32'h5A5AA5A5, 4'hF, 2'd0);
    rd(32'h3FC, 32'h5A5AA5A5, 2'd0);
    wr(32'h400, 32'h22222222, 4'hF, 2'd2);
    rd(32'h3FF, 32'h5A5AA5A5, 2'd0);
    wr(32'h3FC, 32'h00000000, 4'h0, 2'd0);
    rd(32'h3FC, 32'h5A5AA5A5, 2'd0);

    // Simultaneous write and read of the same word: read sees old value
    write_req = 1; write_addr = 32'h000; write_data = 32'h01020304; write_strb = 4'hF;
    read_req = 1; read_addr = 32'h000;
    tick();
    write_req = 0; read_req = 0;
    repeat (4) tick();
    chk("simul_read_old", read_data, 32'hDEADBEEF);
    chk("simul_write_resp", 32'(write_resp), 32'd0);
    rd(32'h000, 32'h01020304, 2'd0);

    // Reset during WRESP aborts the write
    write_req = 1; write_addr = 32'h000; write_data = 32'h77777777; write_strb = 4'hF;
    tick();            // T0
    write_req = 0;
    tick();            // T1
    tick();            // T2, master now waiting for B
    reset = 1;
    tick();            // T3 edge sees reset
    chk("abort_write_done", 32'(write_done), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_write_resp", 32'(write_resp), 32'd0);
    reset = 0;
    tick();
    chk("abort_no_late_done", 32'(write_done), 32'd0);
    rd(32'h000, 32'h00000000, 2'd0);

    // Requests while busy are ignored
    dones = 0;
    write_req = 1; write_addr = 32'h008; write_data = 32'h0BADF00D; write_strb = 4'hF;
    repeat (4) begin tick(); if (write_done) dones++; end
    write_req = 0;
    repeat (6) begin tick(); if (write_done) dones++; end
    chk("busy_single_done", 32'(dones), 32'd1);
    rd(32'h008, 32'h0BADF00D, 2'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      write_req  = ($urandom_range(0, 2) == 0);
      write_addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 'h7F));
      write_data = $urandom;
      write_strb = 4'($urandom_range(0, 15));
      read_req   = ($urandom_range(0, 2) == 0);
      read_addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 'h7F));
      tick();
    end
    reset = 0; write_req = 0; read_req = 0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
